// File: rtl/bsg_two_fifo_ctrl_w16.sv
// Pointer/handshake controller for an external 2-entry 1R1W memory; head data is combinational from memory,
// enqueue is visible after one edge (no bypass from empty); ready_o drops when full, v_i is then ignored.
module bsg_two_fifo_ctrl_w16 #(
  parameter int width_p = 16,
  parameter int els_p   = 2,
  localparam int lg_els = $clog2(els_p)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic [lg_els:0]    count_o,
  output logic               err_o,
  output logic               mem_w_v_o,
  output logic [lg_els-1:0]  mem_w_addr_o,
  output logic [width_p-1:0] mem_w_data_o,
  output logic               mem_r_v_o,
  output logic [lg_els-1:0]  mem_r_addr_o,
  input  logic [width_p-1:0] mem_r_data_i
);

  localparam logic [lg_els:0] full_cnt = (lg_els+1)'(els_p);

  logic [lg_els-1:0] wptr, rptr;
  logic [lg_els:0]   count;
  logic              err;
  logic              enq, deq;

  assign ready_o = (count != full_cnt);
  assign v_o     = (count != '0);
  assign count_o = count;
  assign err_o   = err;

  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  // Write at wptr==rptr only happens when empty, where the read port is idle.
  assign mem_w_v_o    = enq;
  assign mem_w_addr_o = wptr;
  assign mem_w_data_o = data_i;
  assign mem_r_v_o    = v_o;
  assign mem_r_addr_o = rptr;
  assign data_o       = mem_r_data_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Dequeue attempt on an empty queue is a sticky protocol violation.
      if (yumi_i & ~v_o) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bsg_two_fifo_ctrl_w16.sv
// Randomized and directed checks of the FIFO controller against a queue model, with a behavioural 2-entry memory.
module tb_bsg_two_fifo_ctrl_w16;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i;
  logic [15:0] data_i;
  logic        ready_o;
  logic        v_o;
  logic [15:0] data_o;
  logic        yumi_i;
  logic [1:0]  count_o;
  logic        err_o;
  logic        mem_w_v_o;
  logic [0:0]  mem_w_addr_o;
  logic [15:0] mem_w_data_o;
  logic        mem_r_v_o;
  logic [0:0]  mem_r_addr_o;
  logic [15:0] mem_r_data_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: contents as an ordered queue plus the sticky error flag.
  logic [15:0] ref_q[$];
  logic        ref_err;

  logic [15:0] mem [2];

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (mem_w_v_o) mem[mem_w_addr_o] <= mem_w_data_o;
  assign mem_r_data_i = mem[mem_r_addr_o];

  bsg_two_fifo_ctrl_w16 dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .count_o(count_o), .err_o(err_o), .mem_w_v_o(mem_w_v_o),
    .mem_w_addr_o(mem_w_addr_o), .mem_w_data_o(mem_w_data_o),
    .mem_r_v_o(mem_r_v_o), .mem_r_addr_o(mem_r_addr_o),
    .mem_r_data_i(mem_r_data_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic exp_v, exp_rdy, exp_w;
    exp_v   = (ref_q.size() != 0);
    exp_rdy = (ref_q.size() != 2);
    exp_w   = v_i && exp_rdy;
    check("ready", 32'(ready_o), 32'(exp_rdy));
    check("v", 32'(v_o), 32'(exp_v));
    check("count", 32'(count_o), 32'(ref_q.size()));
    check("err", 32'(err_o), 32'(ref_err));
    check("mem_w_v", 32'(mem_w_v_o), 32'(exp_w));
    check("mem_r_v", 32'(mem_r_v_o), 32'(exp_v));
    if (exp_w) check("mem_w_data", 32'(mem_w_data_o), 32'(data_i));
    if (exp_v) check("data_o", 32'(data_o), 32'(ref_q[0]));
    check("same_addr", 32'(mem_w_v_o & mem_r_v_o & (mem_w_addr_o == mem_r_addr_o)), 32'd0);
  endtask

  // One cycle: drive, check mid-cycle, then advance the model at the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic y);
    logic exp_v, exp_rdy;
    v_i = v; data_i = d; yumi_i = y;
    @(negedge clk_i);
    check_outputs();
    @(posedge clk_i);
    exp_v   = (ref_q.size() != 0);
    exp_rdy = (ref_q.size() != 2);
    if (y && !exp_v) ref_err = 1'b1;
    if (y && exp_v) void'(ref_q.pop_front());
    if (v && exp_rdy) ref_q.push_back(d);
    #1;
  endtask

  // Pulse reset between edges and confirm outputs clear before the next edge.
  task automatic pulse_reset();
    v_i = 1'b0; yumi_i = 1'b0;
    #2 reset_n_i = 1'b0;
    #1;
    check("rst_v", 32'(v_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_mem_w_v", 32'(mem_w_v_o), 32'd0);
    check("rst_mem_r_v", 32'(mem_r_v_o), 32'd0);
    #1 reset_n_i = 1'b1;
    ref_q.delete();
    ref_err = 1'b0;
  endtask

  initial begin
    reset_n_i = 1'b0; v_i = 1'b0; data_i = '0; yumi_i = 1'b0; ref_err = 1'b0;
    repeat (2) @(posedge clk_i);
    #2 reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Idle after reset
    repeat (2) step(1'b0, 16'h0, 1'b0);

    // Fill then drain
    step(1'b1, 16'hA5A5, 1'b0);
    step(1'b1, 16'h5A5A, 1'b0);
    @(negedge clk_i);
    check("full_count", 32'(count_o), 32'd2);
    check("full_ready", 32'(ready_o), 32'd0);
    @(posedge clk_i); #1;
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);

    // Streaming at count 1, pointers wrapping every other word
    step(1'b1, 16'h0000, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b1);
    @(negedge clk_i);
    check("stream_count", 32'(count_o), 32'd1);
    check("stream_head", 32'(data_o), 32'd8);
    @(posedge clk_i); #1;

    // Full with v_i held, then one yumi lets 0xFFFF in
    step(1'b1, 16'h0009, 1'b0);
    repeat (3) step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 16'hFFFF, 1'b1);
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);

    // Protocol error is sticky through legal traffic
    step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'h1111, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);

    // Async reset mid-operation with the queue full
    step(1'b1, 16'hBEEF, 1'b0);
    step(1'b1, 16'hCAFE, 1'b0);
    pulse_reset();
    @(posedge clk_i); #1;
    step(1'b1, 16'h1234, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b1);

    // Random traffic; yumi on empty is rare, and reset clears the resulting error
    for (int i = 0; i < 400; i++) begin
      logic rv, ry;
      rv = ($urandom_range(0, 3) != 0);
      ry = ($urandom_range(0, 2) != 0);
      if (ref_q.size() == 0 && $urandom_range(0, 19) != 0) ry = 1'b0;
      step(rv, 16'($urandom), ry);
      if (i % 100 == 99) begin
        pulse_reset();
        @(posedge clk_i); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
